// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel registered valid/ready stream mux.
// Forced-select or round-robin arbitration with optional packet lock.
module rr_stream_mux #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 8,
  parameter bit LOCK_ON_LAST = 1'b1,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  input  logic                     sel_force_en,
  input  logic [CH_W-1:0]          sel_force,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     w_ptr_nxt;
  logic [CH_W-1:0]     r_lock_ch;
  logic [CH_W-1:0]     w_lock_ch_nxt;

  logic [2*N_CH-1:0]   w_vv;
  logic [2*N_CH-1:0]   w_rot;
  logic [CH_W-1:0]     w_rr_gnt;
  logic                w_rr_v;
  logic                w_frc_ok;
  logic [CH_W-1:0]     w_gnt;
  logic                w_gnt_v;
  logic                w_accept;
  logic                w_xfer;
  logic                w_sel_v;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_accept = !out_valid || out_ready;
  assign w_frc_ok = (int'(sel_force) < N_CH);

  // Rotate valids so bit 0 is the channel at the rr pointer.
  assign w_vv  = {in_valid, in_valid};
  assign w_rot = w_vv >> r_ptr;

  always_comb begin
    int t;
    t        = 0;
    w_rr_gnt = '0;
    w_rr_v   = 1'b0;
    for (int k = N_CH-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        t = int'(r_ptr) + k;
        if (t >= N_CH) t = t - N_CH;
        w_rr_gnt = CH_W'(t);
        w_rr_v   = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt   = w_rr_gnt;
    w_gnt_v = w_rr_v;
    if (r_state == S_LOCKED) begin
      w_gnt   = r_lock_ch;
      w_gnt_v = 1'b1;
    end else if (sel_force_en) begin
      w_gnt   = sel_force;
      w_gnt_v = w_frc_ok;
    end
  end

  always_comb begin
    w_sel_v    = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt == CH_W'(i)) begin
        w_sel_v     = in_valid[i];
        w_sel_last  = in_last[i];
        w_sel_data  = in_data[i*DATA_W +: DATA_W];
        in_ready[i] = w_accept && w_gnt_v;
      end
    end
  end

  assign w_xfer = w_accept && w_gnt_v && w_sel_v;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_lock_ch_nxt = r_lock_ch;
    if (w_xfer) begin
      if (!sel_force_en) begin
        w_ptr_nxt = (int'(w_gnt) == N_CH-1) ? '0
                  : w_gnt + CH_W'(1);
      end
      unique case (r_state)
        S_IDLE: begin
          if (LOCK_ON_LAST && !w_sel_last) begin
            w_state_nxt   = S_LOCKED;
            w_lock_ch_nxt = w_gnt;
          end
        end
        S_LOCKED: begin
          if (w_sel_last) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (w_accept) begin
      out_valid <= w_xfer;
      if (w_xfer) begin
        out_data <= w_sel_data;
        out_last <= w_sel_last;
        out_ch   <= w_gnt;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: forced, round-robin,
// backpressure, packet lock, async reset and out-of-range force.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        sel_force_en;
  logic [1:0]  sel_force;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic [4:0]  v5_in_valid;
  logic [39:0] v5_in_data;
  logic [4:0]  v5_in_last;
  logic [4:0]  v5_in_ready;
  logic        v5_sel_force_en;
  logic [2:0]  v5_sel_force;
  logic        v5_out_valid;
  logic [7:0]  v5_out_data;
  logic        v5_out_last;
  logic [2:0]  v5_out_ch;
  logic        v5_out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.N_CH(4), .DATA_W(8), .LOCK_ON_LAST(1'b1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .sel_force_en (sel_force_en),
    .sel_force    (sel_force),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ch       (out_ch),
    .out_ready    (out_ready)
  );

  rr_stream_mux #(.N_CH(5), .DATA_W(8), .LOCK_ON_LAST(1'b1)) u_dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (v5_in_valid),
    .in_data      (v5_in_data),
    .in_last      (v5_in_last),
    .in_ready     (v5_in_ready),
    .sel_force_en (v5_sel_force_en),
    .sel_force    (v5_sel_force),
    .out_valid    (v5_out_valid),
    .out_data     (v5_out_data),
    .out_last     (v5_out_last),
    .out_ch       (v5_out_ch),
    .out_ready    (v5_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    in_valid        = '0;
    in_data         = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_last         = '0;
    sel_force_en    = 1'b0;
    sel_force       = '0;
    out_ready       = 1'b0;
    v5_in_valid     = '0;
    v5_in_data      = {8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
    v5_in_last      = 5'b11111;
    v5_sel_force_en = 1'b0;
    v5_sel_force    = '0;
    v5_out_ready    = 1'b1;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1. forced select of channel 1
    in_valid     = 4'hF;
    in_last      = 4'hF;
    sel_force_en = 1'b1;
    sel_force    = 2'd1;
    out_ready    = 1'b1;
    #1;
    chk("frc_in_ready", 32'(in_ready), 32'h2);
    step();
    chk("frc_out_valid", 32'(out_valid), 32'd1);
    chk("frc_out_data",  32'(out_data),  32'hA1);
    chk("frc_out_ch",    32'(out_ch),    32'd1);

    // 2. round-robin from ptr 0 (forced beat left ptr alone)
    sel_force_en = 1'b0;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_out_ch",    32'(out_ch),    32'(k % 4));
      chk("rr_out_data",  32'(out_data),  32'(8'hA0 + (k % 4)));
      chk("rr_out_valid", 32'(out_valid), 32'd1);
    end

    // 3. backpressure holding ch0 beat; ptr now 1
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      chk("bp_out_data",  32'(out_data),  32'hA0);
      chk("bp_out_ch",    32'(out_ch),    32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'h2);
    step();
    chk("bp_next_ch",   32'(out_ch),   32'd1);
    chk("bp_next_data", 32'(out_data), 32'hA1);
    step();
    chk("bp_after_ch",  32'(out_ch),   32'd2);

    // drain, then a ch1 beat to put ptr at 2
    in_valid = 4'h0;
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0010;
    step();
    chk("setup_ch1", 32'(out_ch), 32'd1);

    // 4. packet lock on ch2 with a mid-packet stall
    in_valid = 4'b0101;
    in_last  = 4'b0001;
    in_data  = {8'hA3, 8'hC0, 8'hA1, 8'hA0};
    #1;
    chk("lk_b1_ready", 32'(in_ready), 32'h4);
    step();
    chk("lk_b1_ch",   32'(out_ch),   32'd2);
    chk("lk_b1_data", 32'(out_data), 32'hC0);
    in_valid = 4'b0001;
    #1;
    chk("lk_stall_ready", 32'(in_ready), 32'h4);
    step();
    chk("lk_gap_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0101;
    in_data  = {8'hA3, 8'hC1, 8'hA1, 8'hA0};
    #1;
    chk("lk_b2_ready", 32'(in_ready), 32'h4);
    step();
    chk("lk_b2_ch",   32'(out_ch),   32'd2);
    chk("lk_b2_data", 32'(out_data), 32'hC1);
    in_last = 4'b0101;
    in_data = {8'hA3, 8'hC2, 8'hA1, 8'hA0};
    #1;
    chk("lk_b3_ready", 32'(in_ready), 32'h4);
    step();
    chk("lk_b3_ch",   32'(out_ch),   32'd2);
    chk("lk_b3_data", 32'(out_data), 32'hC2);
    chk("lk_b3_last", 32'(out_last), 32'd1);
    in_valid = 4'b0001;
    #1;
    chk("lk_rel_ready", 32'(in_ready), 32'h1);
    step();
    chk("lk_then_ch0", 32'(out_ch),   32'd0);
    chk("lk_then_val", 32'(out_valid), 32'd1);

    // 5. reset while locked on ch1 with a held beat
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    step();
    chk("mr_ch1",   32'(out_ch),   32'd1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(out_valid), 32'd0);
    chk("mr_async_ch",    32'(out_ch),    32'd0);
    step();
    rst_n     = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("mr_grant0", 32'(in_ready), 32'h1);
    step();
    chk("mr_out_ch", 32'(out_ch), 32'd0);

    // 6. out-of-range force on a 5-channel instance
    v5_in_valid     = 5'b11111;
    v5_sel_force_en = 1'b1;
    v5_sel_force    = 3'd5;
    #1;
    chk("oor_in_ready", 32'(v5_in_ready), 32'h0);
    step();
    chk("oor_valid_a", 32'(v5_out_valid), 32'd0);
    step();
    chk("oor_valid_b", 32'(v5_out_valid), 32'd0);
    v5_sel_force_en = 1'b0;
    #1;
    chk("oor_rr_ready", 32'(v5_in_ready), 32'h01);
    step();
    chk("oor_rr_valid", 32'(v5_out_valid), 32'd1);
    chk("oor_rr_ch",    32'(v5_out_ch),    32'd0);
    chk("oor_rr_data",  32'(v5_out_data),  32'h50);
    step();
    chk("oor_rr_ch1",   32'(v5_out_ch),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
